// File: rtl/reg_file_scb.sv
// ============================================================================
//  Module      : reg_file_scb
//  Description : Register file with write-to-read forwarding and a pending-bit
//                scoreboard that raises stallOut on RAW/WAW hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_scb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int PORT_REG = 3,
    parameter int BYPASS   = 1
) (
    input  logic              clkIn,
    input  logic              resetIn,
    input  logic [ADDR_W-1:0] rs1In,
    input  logic [ADDR_W-1:0] rs2In,
    input  logic [ADDR_W-1:0] rdIn,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              writeIn,
    input  logic              issueIn,
    input  logic [ADDR_W-1:0] issueRdIn,
    output logic [DATA_W-1:0] data1Out,
    output logic [DATA_W-1:0] data2Out,
    output logic              stallOut,
    output logic [DATA_W-1:0] portOut,
    output logic [ADDR_W:0]   pendCntOut
);

    localparam int            NREG    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   pend_q;
    logic [NREG-1:0]   pend_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;

    logic w_wr;
    logic w_fwd1;
    logic w_fwd2;
    logic w_raw1;
    logic w_raw2;
    logic w_waw;
    logic w_set;
    logic w_clr;

    assign w_wr   = writeIn && (rdIn != '0);
    assign w_fwd1 = (BYPASS != 0) && w_wr && (rdIn == rs1In);
    assign w_fwd2 = (BYPASS != 0) && w_wr && (rdIn == rs2In);

    always_comb begin
        data1Out = regs_q[rs1In];
        if (rs1In == '0)
            data1Out = '0;
        else if (w_fwd1)
            data1Out = dataIn;
    end

    always_comb begin
        data2Out = regs_q[rs2In];
        if (rs2In == '0)
            data2Out = '0;
        else if (w_fwd2)
            data2Out = dataIn;
    end

    // A same-cycle writeback resolves a RAW only if it can be forwarded,
    // but always resolves a WAW since the scoreboard clear and set coincide.
    assign w_raw1   = (rs1In != '0) && pend_q[rs1In] && !w_fwd1;
    assign w_raw2   = (rs2In != '0) && pend_q[rs2In] && !w_fwd2;
    assign w_waw    = issueIn && (issueRdIn != '0) && pend_q[issueRdIn]
                      && !(writeIn && (rdIn == issueRdIn));
    assign stallOut = w_raw1 || w_raw2 || w_waw;

    assign w_set = issueIn && (issueRdIn != '0) && !stallOut;
    assign w_clr = w_wr && pend_q[rdIn];

    always_comb begin
        regs_d    = regs_q;
        regs_d[0] = '0;
        if (w_wr)
            regs_d[rdIn] = dataIn;
    end

    // Set is applied after clear so an issue wins over a coinciding writeback.
    always_comb begin
        pend_d = pend_q;
        if (w_clr)
            pend_d[rdIn] = 1'b0;
        if (w_set)
            pend_d[issueRdIn] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (w_set && !w_clr)
            cnt_d = cnt_q + CNT_ONE;
        else if (w_clr && !w_set)
            cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pendCntOut = cnt_q;

    generate
        if (PORT_REG == 0) begin : g_port_zero
            assign portOut = '0;
        end else begin : g_port_reg
            assign portOut = regs_q[PORT_REG];
        end
    endgenerate

endmodule

`default_nettype wire
